// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipe: hazard priority, deferred
// mispredict redirect across memory freezes, and saturating event counters.
module pipe_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stl,
  input  logic             mm_stl,
  input  logic             id_ld_hz,
  input  logic             ex_mis,
  input  logic [31:0]      ex_tgt,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic             redir_en,
  output logic [31:0]      redir_pc,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYC - 1);

  localparam logic [4:0] S_FRZ = 5'b01111;
  localparam logic [4:0] S_LDU = 5'b00011;
  localparam logic [4:0] F_LDU = 5'b00100;
  localparam logic [4:0] S_PC  = 5'b00001;
  localparam logic [4:0] F_IF  = 5'b00010;
  localparam logic [4:0] F_MIS = 5'b00110;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    FLUSH
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   pend_tgt, pend_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic [4:0]    stl_c, fl_c;
  logic          ren_c;
  logic [31:0]   rtgt;
  logic [CNT_W-1:0] cs_q, cf_q;

  always_comb begin
    state_nx = state;
    pend_nx  = pend_tgt;
    fcnt_nx  = fcnt;
    stl_c    = '0;
    fl_c     = '0;
    ren_c    = 1'b0;
    rtgt     = ex_tgt;
    unique case (state)
      RUN: begin
        priority case (1'b1)
          mm_stl: begin
            stl_c = S_FRZ;
            if (ex_mis) begin
              pend_nx  = ex_tgt;
              state_nx = PEND;
            end
          end
          ex_mis: begin
            ren_c = 1'b1;
            fl_c  = F_MIS;
            if (FLUSH_CYC > 1) begin
              fcnt_nx  = FRELOAD;
              state_nx = FLUSH;
            end
          end
          id_ld_hz: begin
            stl_c = S_LDU;
            fl_c  = F_LDU;
          end
          if_stl: begin
            stl_c = S_PC;
            fl_c  = F_IF;
          end
          default: ;
        endcase
      end
      PEND: begin
        if (mm_stl) begin
          stl_c = S_FRZ;
        end else begin
          ren_c = 1'b1;
          rtgt  = pend_tgt;
          fl_c  = F_MIS;
          if (FLUSH_CYC > 1) begin
            fcnt_nx  = FRELOAD;
            state_nx = FLUSH;
          end else begin
            state_nx = RUN;
          end
        end
      end
      FLUSH: begin
        priority case (1'b1)
          mm_stl: begin
            stl_c = S_FRZ;
            // EX is frozen too, so a mispredict here waits like in RUN
            if (ex_mis) begin
              pend_nx  = ex_tgt;
              state_nx = PEND;
            end
          end
          ex_mis: begin
            ren_c   = 1'b1;
            fl_c    = F_MIS;
            fcnt_nx = FRELOAD;
          end
          default: begin
            stl_c = S_PC;
            fl_c  = F_IF;
            if (fcnt == FW'(1)) state_nx = RUN;
            else fcnt_nx = fcnt - FW'(1);
          end
        endcase
      end
      default: state_nx = RUN;
    endcase
  end

  assign stall    = rst ? '0 : stl_c;
  assign flush    = rst ? '0 : fl_c;
  assign redir_en = rst ? 1'b0 : ren_c;
  assign redir_pc = redir_en ? (rtgt & 32'hFFFF_FFFE) : '0;
  assign cnt_stall = rst ? '0 : cs_q;
  assign cnt_flush = rst ? '0 : cf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pend_tgt <= '0;
      fcnt     <= '0;
    end else begin
      state    <= state_nx;
      pend_tgt <= pend_nx;
      fcnt     <= fcnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= '0;
      cf_q <= '0;
    end else begin
      if (|stall && cs_q != '1) cs_q <= cs_q + CNT_W'(1);
      if (redir_en && cf_q != '1) cf_q <= cf_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench: two pipe_ctrl configurations driven in lockstep and
// compared each cycle against a behavioural model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_stl = 1'b0;
  logic        mm_stl = 1'b0;
  logic        id_ld_hz = 1'b0;
  logic        ex_mis = 1'b0;
  logic [31:0] ex_tgt = '0;

  logic [4:0]  stall0, flush0, stall1, flush1;
  logic        ren0, ren1;
  logic [31:0] rpc0, rpc1;
  logic [31:0] cs0, cf0;
  logic [3:0]  cs1, cf1;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYC(1), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .if_stl(if_stl), .mm_stl(mm_stl),
    .id_ld_hz(id_ld_hz), .ex_mis(ex_mis), .ex_tgt(ex_tgt),
    .stall(stall0), .flush(flush0), .redir_en(ren0),
    .redir_pc(rpc0), .cnt_stall(cs0), .cnt_flush(cf0)
  );

  pipe_ctrl #(.FLUSH_CYC(3), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .if_stl(if_stl), .mm_stl(mm_stl),
    .id_ld_hz(id_ld_hz), .ex_mis(ex_mis), .ex_tgt(ex_tgt),
    .stall(stall1), .flush(flush1), .redir_en(ren1),
    .redir_pc(rpc1), .cnt_stall(cs1), .cnt_flush(cf1)
  );

  typedef struct {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        ren;
    logic [31:0] rpc;
    logic [31:0] cs;
    logic [31:0] cf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // model state: pending redirect flag/target, flush cycles left, counts
  bit          pend[2];
  logic [31:0] ptgt[2];
  int          fleft[2];
  longint      cs[2];
  longint      cf[2];
  int          fc[2] = '{1, 3};
  longint      cmax[2] = '{64'hFFFF_FFFF, 64'hF};

  task automatic model_step(input int d);
    exp_t e;
    e = '{default: '0};
    if (rst) begin
      pend[d] = 0;
      ptgt[d] = '0;
      fleft[d] = 0;
      cs[d] = 0;
      cf[d] = 0;
    end else begin
      e.cs = cs[d][31:0];
      e.cf = cf[d][31:0];
      if (pend[d]) begin
        if (mm_stl) e.stall = 5'b01111;
        else begin
          e.ren = 1;
          e.rpc = ptgt[d] & ~32'd1;
          e.flush = 5'b00110;
          fleft[d] = fc[d] - 1;
          pend[d] = 0;
        end
      end else if (mm_stl) begin
        e.stall = 5'b01111;
        if (ex_mis) begin
          pend[d] = 1;
          ptgt[d] = ex_tgt;
          fleft[d] = 0;
        end
      end else if (ex_mis) begin
        e.ren = 1;
        e.rpc = ex_tgt & ~32'd1;
        e.flush = 5'b00110;
        fleft[d] = fc[d] - 1;
      end else if (fleft[d] > 0) begin
        e.stall = 5'b00001;
        e.flush = 5'b00010;
        fleft[d]--;
      end else if (id_ld_hz) begin
        e.stall = 5'b00011;
        e.flush = 5'b00100;
      end else if (if_stl) begin
        e.stall = 5'b00001;
        e.flush = 5'b00010;
      end
      if (e.stall != 0 && cs[d] < cmax[d]) cs[d]++;
      if (e.ren && cf[d] < cmax[d]) cf[d]++;
    end
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit ifs, input bit mm,
                     input bit ld, input bit mis, input logic [31:0] t);
    @(negedge clk);
    rst = r;
    if_stl = ifs;
    mm_stl = mm;
    id_ld_hz = ld;
    ex_mis = mis;
    ex_tgt = t;
    model_step(0);
    model_step(1);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".stall"}, 32'(a.stall), 32'(e.stall));
    chk({tag, ".flush"}, 32'(a.flush), 32'(e.flush));
    chk({tag, ".redir_en"}, 32'(a.ren), 32'(e.ren));
    chk({tag, ".redir_pc"}, a.rpc, e.rpc);
    chk({tag, ".cnt_stall"}, a.cs, e.cs);
    chk({tag, ".cnt_flush"}, a.cf, e.cf);
  endtask

  initial begin : monitor
    exp_t a;
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) begin
        a = '{stall0, flush0, ren0, rpc0, cs0, cf0};
        cmp("u0", a, q0.pop_front());
      end
      if (q1.size() > 0) begin
        a = '{stall1, flush1, ren1, rpc1, 32'(cs1), 32'(cf1)};
        cmp("u1", a, q1.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // T1 reset with active inputs
    cyc(1, 0, 1, 0, 1, 32'h44);
    cyc(1, 0, 1, 0, 1, 32'h44);
    // T2 mispredict
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_1235);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // T3 deferred redirect
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h80);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // T4 priority
    cyc(0, 1, 0, 1, 1, 32'h200);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // T5 flush sequence, then one extended by a freeze
    cyc(0, 0, 0, 0, 1, 32'h300);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h400);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    // reset mid-pend discards the target
    cyc(0, 0, 1, 0, 1, 32'h500);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // T6 counter saturation on the narrow instance
    repeat (20) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 6) == 0),
          $urandom);
    end
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
